fuzzy_wavg_defuzz: RTL

//  Weighted-average (singleton) defuzzifier; stage directly downstream of the trapezoid MF evaluators / rule firing.

---
 rtl/fuzzy_wavg_defuzz_if.sv | 27 ++
 rtl/fuzzy_wavg_defuzz.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_wavg_defuzz_if.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_wavg_defuzz_if
// Brief    : Valid/ready input pair stream and result stream for the defuzzifier.
// Revision : 1.0
// ============================================================================
interface fuzzy_wavg_defuzz_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mu;
  logic [7:0]  in_z;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic        out_zero;

  modport master (
    output in_valid, in_mu, in_z, out_ready,
    input  in_ready, out_valid, out_y, out_zero
  );

  modport slave (
    input  in_valid, in_mu, in_z, out_ready,
    output in_ready, out_valid, out_y, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/fuzzy_wavg_defuzz.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_wavg_defuzz
// Brief    : Singleton weighted-average defuzzifier, y = sum(mu*z)/sum(mu).
// Revision : 1.0
// ============================================================================
module fuzzy_wavg_defuzz #(
  parameter int N_RULES = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  fuzzy_wavg_defuzz_if.slave bus
);

  localparam int c_SW_W  = 16 + CNT_W;
  localparam int c_SZ_W  = 24 + CNT_W + 1;
  localparam int c_DEN_W = c_SW_W + 8;
  localparam int c_MAG_W = c_SZ_W;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_RULES - 1);

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_DIV = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_div_done;

  logic [c_SW_W-1:0]        r_sum_w;
  logic signed [c_SZ_W-1:0] r_sum_wz;
  logic [CNT_W-1:0]         r_cnt;
  logic [3:0]               r_div_cnt;
  logic [c_MAG_W-1:0]       r_rem;
  logic [c_DEN_W-1:0]       r_den;
  logic [8:0]               r_quo;
  logic                     r_neg;
  logic                     r_zero_den;
  logic                     r_out_valid;
  logic [7:0]               r_out_y;
  logic                     r_out_zero;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_last;
  logic signed [23:0]       w_prod;
  logic [c_SW_W-1:0]        w_sum_w_nxt;
  logic signed [c_SZ_W-1:0] w_sum_wz_nxt;
  logic [c_MAG_W-1:0]       w_mag_nxt;
  logic                     w_ge;
  logic [c_MAG_W-1:0]       w_rem_sub;
  logic [8:0]               w_quo_nxt;
  logic [9:0]               w_quo_neg;
  logic [7:0]               w_y_fin;

  assign w_in_ready = (r_state == S_ACC) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = w_accept && (r_cnt == c_LAST);

  assign w_prod       = $signed(bus.in_mu) * $signed(bus.in_z);
  assign w_sum_w_nxt  = r_sum_w + c_SW_W'(bus.in_mu);
  assign w_sum_wz_nxt = r_sum_wz + $signed({{(c_SZ_W-24){w_prod[23]}}, w_prod});
  assign w_mag_nxt    = w_sum_wz_nxt[c_SZ_W-1] ? c_MAG_W'(-w_sum_wz_nxt)
                                               : c_MAG_W'(w_sum_wz_nxt);

  // Denominator starts pre-shifted by 8 so each cycle resolves one of 9 quotient bits.
  assign w_ge      = r_rem >= c_MAG_W'(r_den);
  assign w_rem_sub = r_rem - c_MAG_W'(r_den);
  assign w_quo_nxt = {r_quo[7:0], w_ge};
  assign w_quo_neg = 10'd0 - {1'b0, w_quo_nxt};

  always_comb begin
    w_y_fin = 8'd0;
    if (r_zero_den) begin
      w_y_fin = 8'd0;
    end else if (r_neg) begin
      w_y_fin = (w_quo_nxt > 9'd128) ? 8'h80 : w_quo_neg[7:0];
    end else begin
      w_y_fin = (w_quo_nxt > 9'd127) ? 8'h7F : w_quo_nxt[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_done  = 1'b0;
    case (r_state)
      S_ACC: begin
        if (bus.in_valid && (r_cnt == c_LAST)) begin
          w_state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if (r_div_cnt == 4'd8) begin
          w_div_done  = 1'b1;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (r_out_valid && bus.out_ready) begin
          w_state_nxt = S_ACC;
        end
      end
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_w     <= '0;
      r_sum_wz    <= '0;
      r_cnt       <= '0;
      r_div_cnt   <= '0;
      r_rem       <= '0;
      r_den       <= '0;
      r_quo       <= '0;
      r_neg       <= 1'b0;
      r_zero_den  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_sum_w  <= w_sum_w_nxt;
            r_sum_wz <= w_sum_wz_nxt;
            if (w_last) begin
              r_cnt      <= '0;
              r_div_cnt  <= '0;
              r_quo      <= '0;
              r_rem      <= w_mag_nxt;
              r_den      <= {w_sum_w_nxt, 8'd0};
              r_neg      <= w_sum_wz_nxt[c_SZ_W-1];
              r_zero_den <= (w_sum_w_nxt == '0);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DIV: begin
          r_div_cnt <= r_div_cnt + 1'b1;
          r_quo     <= w_quo_nxt;
          r_den     <= r_den >> 1;
          if (w_ge) begin
            r_rem <= w_rem_sub;
          end
          if (w_div_done) begin
            r_out_y     <= w_y_fin;
            r_out_zero  <= r_zero_den;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_sum_w     <= '0;
            r_sum_wz    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_zero  = r_out_zero;

endmodule
`default_nettype wire
